// File: rtl/adam_stream_pkg.sv
// Shared stream helpers: round-robin wrap-search used by the stream arbiters.
package adam_stream_pkg;

  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  // First set bit of valid_vec searching ptr, ptr+1, ... wrapping at n-1; returns ptr when none is set.
  function automatic logic [RR_IDX_W-1:0] rr_first(
    input logic [RR_MAX-1:0]   valid_vec,
    input logic [RR_IDX_W-1:0] ptr,
    input int unsigned         n
  );
    logic [RR_IDX_W-1:0] idx;
    logic [RR_IDX_W-1:0] sel;
    logic                found;
    idx   = ptr;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        if (!found && valid_vec[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
        idx = (32'(idx) >= n - 1) ? '0 : idx + RR_IDX_W'(1);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/adam_stream_skid.sv
// Registered skid stage: full throughput, ready/valid fully cut between its two sides.
module adam_stream_skid #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  T     slv_data,
  input  logic slv_valid,
  output logic slv_ready,
  output T     mst_data,
  output logic mst_valid,
  input  logic mst_ready
);

  T     skid_data;
  logic skid_valid;
  logic out_free;

  assign slv_ready = !skid_valid;
  assign out_free  = !mst_valid || mst_ready;

  // Output register refills from the skid first; skid only fills while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_valid  <= 1'b0;
      mst_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        mst_data   <= skid_data;
        mst_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        mst_valid <= slv_valid;
        if (slv_valid) mst_data <= slv_data;
      end
    end else if (slv_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= slv_data;
    end
  end

endmodule

// File: rtl/adam_stream_arb.sv
// Round-robin N-to-1 stream arbiter with burst locking, registered through a skid stage.
module adam_stream_arb
  import adam_stream_pkg::*;
#(
  parameter type         T         = logic [7:0],
  parameter int unsigned NO_SLVS   = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  T                   slv_data [NO_SLVS],
  input  logic [NO_SLVS-1:0] slv_valid,
  output logic [NO_SLVS-1:0] slv_ready,
  output T                   mst_data,
  output logic               mst_valid,
  input  logic               mst_ready
);

  localparam int unsigned IDX_W = (NO_SLVS > 1) ? $clog2(NO_SLVS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST      = IDX_W'(NO_SLVS - 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   search;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_next;
  logic [IDX_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   cnt_eff;
  logic [NO_SLVS-1:0] gnt_oh;
  logic               locked;
  logic               abort;
  logic               gnt_valid;
  logic               xfer;
  logic               skid_ready;
  T                   arb_data;

  // During a burst ptr holds the current grantee, so locking is a plain lookup.
  always_comb begin
    search    = IDX_W'(rr_first(RR_MAX'(slv_valid), RR_IDX_W'(ptr), NO_SLVS));
    locked    = (cnt != '0) && slv_valid[ptr];
    abort     = (cnt != '0) && !slv_valid[ptr];
    gnt       = locked ? ptr : search;
    gnt_valid = |slv_valid;
    gnt_next  = (gnt == LAST) ? '0 : gnt + IDX_W'(1);
    ptr_next  = (ptr == LAST) ? '0 : ptr + IDX_W'(1);
    cnt_eff   = locked ? cnt : '0;
    xfer      = gnt_valid && skid_ready && !rst;
  end

  always_comb begin
    gnt_oh   = '0;
    arb_data = '0;
    for (int unsigned i = 0; i < NO_SLVS; i++) begin
      gnt_oh[i] = gnt_valid && (gnt == IDX_W'(i));
    end
    for (int unsigned i = 0; i < NO_SLVS; i++) begin
      if (gnt_oh[i]) arb_data = slv_data[i];
    end
    slv_ready = gnt_oh & {NO_SLVS{skid_ready && !rst}};
  end

  // A transfer that starts a new burst after an abort counts from zero via cnt_eff.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (xfer) begin
      if (cnt_eff == BURST_END) begin
        ptr <= gnt_next;
        cnt <= '0;
      end else begin
        ptr <= gnt;
        cnt <= cnt_eff + CNT_W'(1);
      end
    end else if (abort) begin
      ptr <= ptr_next;
      cnt <= '0;
    end
  end

  adam_stream_skid #(.T(T)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .slv_data  (arb_data),
    .slv_valid (gnt_valid && !rst),
    .slv_ready (skid_ready),
    .mst_data  (mst_data),
    .mst_valid (mst_valid),
    .mst_ready (mst_ready)
  );

endmodule

// File: tb/tb_adam_stream_arb.sv
// Scoreboard bench for adam_stream_arb: directed scenarios plus random traffic against a reference model.
module tb_adam_stream_arb;

  localparam int N       = 3;
  localparam int MB      = 2;
  localparam int MAX_CYC = 5000;
  typedef logic [7:0] data_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  data_t        slv_data [N];
  logic [N-1:0] slv_valid = '0;
  logic [N-1:0] slv_ready;
  data_t        mst_data;
  logic         mst_valid;
  logic         mst_ready = 1'b1;

  always #5 clk = ~clk;

  adam_stream_arb #(.T(data_t), .NO_SLVS(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .slv_data  (slv_data),
    .slv_valid (slv_valid),
    .slv_ready (slv_ready),
    .mst_data  (mst_data),
    .mst_valid (mst_valid),
    .mst_ready (mst_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;

  // Reference model: grant pointer, burst count, current grantee, beats held downstream.
  int    m_ptr, m_cnt, m_cur, occ;
  int    waitx [N];
  int    seqn  [N];
  bit    vld   [N];
  data_t dat   [N];
  bit    rst_d, rdy_d;
  data_t exp_q [$];
  data_t obs   [$];
  int    obs_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic offer(input int i);
    vld[i] = 1'b1;
    dat[i] = data_t'(((i & 15) << 4) | (seqn[i] & 15));
    seqn[i]++;
  endtask

  function automatic bit any_vld();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= vld[i];
    return a;
  endfunction

  // One clock: drive after the edge, predict and check at the falling edge, advance the model.
  task automatic step();
    int g;
    bit room, acc, out_hs;
    int exp_rdy;
    @(posedge clk);
    #1;
    rst       = rst_d;
    mst_ready = rdy_d;
    for (int i = 0; i < N; i++) begin
      slv_valid[i] = vld[i];
      slv_data[i]  = dat[i];
    end
    @(negedge clk);
    if (rst_d) begin
      chk(slv_ready == '0, "ready_in_reset", int'(slv_ready), 0);
      exp_q.delete();
      occ = 0; m_ptr = 0; m_cnt = 0; m_cur = 0;
      for (int i = 0; i < N; i++) waitx[i] = 0;
    end else begin
      if (m_cnt > 0 && !vld[m_cur]) begin
        m_ptr = (m_cur + 1) % N;
        m_cnt = 0;
      end
      g = -1;
      if (m_cnt > 0) g = m_cur;
      else for (int k = 0; k < N; k++) if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      room    = (occ < 2);
      acc     = (g >= 0) && room;
      exp_rdy = acc ? (1 << g) : 0;
      chk(int'(slv_ready) == exp_rdy, "slv_ready", int'(slv_ready), exp_rdy);
      chk(mst_valid == (occ > 0), "mst_valid", int'(mst_valid), int'(occ > 0));
      out_hs = rdy_d && (occ > 0);
      if (acc) begin
        chk(waitx[g] <= (N - 1) * MB, "fairness", waitx[g], (N - 1) * MB);
        waitx[g] = 0;
        exp_q.push_back(dat[g]);
        vld[g] = 1'b0;
        for (int i = 0; i < N; i++) if (vld[i]) waitx[i]++;
        if (m_cnt == 0) m_cur = g;
        m_cnt++;
        if (m_cnt == MB) begin
          m_ptr = (g + 1) % N;
          m_cnt = 0;
        end
        n_acc++;
      end
      occ = occ + int'(acc) - int'(out_hs);
    end
  endtask

  task automatic do_reset();
    rst_d = 1'b1;
    step();
    step();
    rst_d = 1'b0;
    for (int i = 0; i < N; i++) seqn[i] = 0;
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    rdy_d = 1'b1;
    while ((any_vld() || exp_q.size() != 0 || occ != 0) && c < max_cyc) begin
      step();
      c++;
    end
    chk(exp_q.size() == 0 && !any_vld(), "drain", exp_q.size(), 0);
  endtask

  // Monitor: every presented beat must match the scoreboard head, including while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mst_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", int'(mst_data), -1);
        end else begin
          chk(mst_data == exp_q[0], "mst_data", int'(mst_data), int'(exp_q[0]));
          if (mst_ready) begin
            void'(exp_q.pop_front());
            obs.push_back(mst_data);
            obs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (MAX_CYC) @(posedge clk);
    $display("FAIL watchdog: cycle budget %0d exceeded", MAX_CYC);
    $fatal(1, "watchdog");
  end

  initial begin
    data_t rr_exp [8];
    data_t tmp;
    int    acc0;
    rr_exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h02, 8'h03};
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; dat[i] = '0; seqn[i] = 0; waitx[i] = 0;
      slv_data[i] = '0;
    end
    m_ptr = 0; m_cnt = 0; m_cur = 0; occ = 0;
    rdy_d = 1'b1;

    // reset
    rst_d = 1'b1;
    repeat (3) step();
    rst_d = 1'b0;
    step();
    chk(mst_data == '0, "reset_data", int'(mst_data), 0);

    // basic
    obs.delete();
    vld[1] = 1'b1;
    dat[1] = 8'h5A;
    drain(20);
    chk(obs.size() == 1, "basic_count", obs.size(), 1);
    if (obs.size() >= 1) chk(obs[0] == 8'h5A, "basic_data", int'(obs[0]), 'h5A);

    // round_robin
    do_reset();
    obs.delete();
    repeat (12) begin
      for (int i = 0; i < N; i++) if (!vld[i]) offer(i);
      step();
    end
    drain(20);
    chk(obs.size() >= 8, "rr_count", obs.size(), 8);
    if (obs.size() >= 8)
      for (int k = 0; k < 8; k++) chk(obs[k] == rr_exp[k], "rr_order", int'(obs[k]), int'(rr_exp[k]));

    // burst_abort
    do_reset();
    obs.delete();
    offer(0);
    offer(2);
    drain(20);
    chk(obs.size() == 2, "abort_count", obs.size(), 2);
    if (obs.size() == 2) begin
      tmp = obs[1];
      chk(tmp[7:4] == 4'h2, "abort_next_port", int'(tmp[7:4]), 2);
    end

    // single_stream
    obs.delete();
    obs_cyc.delete();
    for (int b = 0; b < 10; b++) begin
      if (!vld[2]) offer(2);
      step();
    end
    drain(20);
    chk(obs.size() == 10, "single_count", obs.size(), 10);
    if (obs.size() == 10) chk(obs_cyc[9] - obs_cyc[0] == 9, "single_no_bubble", obs_cyc[9] - obs_cyc[0], 9);

    // stall
    obs.delete();
    rdy_d = 1'b0;
    acc0  = n_acc;
    for (int c = 0; c < 4; c++) begin
      if (!vld[0] && n_acc - acc0 < 2) offer(0);
      step();
    end
    chk(n_acc - acc0 == 2, "stall_absorbed", n_acc - acc0, 2);
    offer(0);
    step();
    chk(slv_ready[0] == 1'b0, "stall_ready_low", int'(slv_ready[0]), 0);
    drain(20);
    chk(obs.size() == 3, "stall_count", obs.size(), 3);

    // reset_mid
    rdy_d = 1'b0;
    acc0  = n_acc;
    for (int c = 0; c < 3; c++) begin
      if (!vld[1] && n_acc - acc0 < 2) offer(1);
      step();
    end
    chk(mst_valid == 1'b1, "reset_mid_preload", int'(mst_valid), 1);
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i]  = 1'b0;
      seqn[i] = 0;
    end
    obs.delete();
    for (int i = 0; i < N; i++) offer(i);
    step();
    chk(mst_valid == 1'b0, "reset_mid_valid", int'(mst_valid), 0);
    drain(20);
    if (obs.size() >= 1) begin
      tmp = obs[0];
      chk(tmp[7:4] == 4'h0, "reset_mid_first_port", int'(tmp[7:4]), 0);
    end else begin
      chk(1'b0, "reset_mid_first_port", obs.size(), 1);
    end

    // random traffic
    for (int c = 0; c < 500; c++) begin
      rdy_d = ($urandom % 100) < 70;
      for (int i = 0; i < N; i++) if (!vld[i] && ($urandom % 100) < 50) offer(i);
      step();
    end
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
